// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the RISC-V load/store funct3 encodings, FSM states and the latched request.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    // Width of the latched address field; the responder's ADDR_W defaults to this.
    localparam int DMEM_ADDR_W = 9;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_e;

    typedef struct packed {
        logic                   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [31:0]            wdata;
        logic [2:0]             funct3;
        logic                   err;
    } dmem_req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane logic: legality check, store byte enables and
// lane-replicated write data, and load lane extraction with sign/zero extension.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic        err,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    logic        legal;
    logic        sign;
    logic [1:0]  size;
    logic [31:0] shifted;

    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    always_comb begin
        legal      = 1'b0;
        err        = 1'b0;
        be         = 4'b0000;
        wdata_lane = '0;
        rdata_ext  = '0;
        size       = funct3[1:0];
        sign       = ~funct3[2];
        shifted    = rword >> {addr_lo, 3'b000};

        unique case (funct3)
            F3_B, F3_H, F3_W: legal = 1'b1;
            F3_BU, F3_HU:     legal = ~we;
            default:          legal = 1'b0;
        endcase

        err = ~legal
            | ((size == 2'b01) & addr_lo[0])
            | ((size == 2'b10) & (addr_lo != 2'b00));

        // Stores replicate the data across lanes so the byte enables alone pick the target.
        unique case (size)
            2'b00: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = {{24{sign & shifted[7]}}, shifted[7:0]};
            end
            2'b01: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = {{16{sign & shifted[15]}}, shifted[15:0]};
            end
            default: begin
                be         = 4'b1111;
                wdata_lane = wdata;
                rdata_ext  = shifted;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder with a valid/ready request port, WAIT_CYC wait states
// and a one-cycle response carrying extended load data or an error flag.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W   = DMEM_ADDR_W,
    parameter int DATA_W   = 32,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [2:0]        req_funct3,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int         DEPTH    = 1 << (ADDR_W - 2);
    localparam logic [3:0] CNT_INIT = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

    dmem_state_e state, state_nx;
    dmem_req_t   lat;
    logic [3:0]  cnt;
    logic        accept, commit;

    logic [DATA_W-1:0] mem [DEPTH];

    // In IDLE the live request drives the lane logic (error check, zero-wait commit);
    // afterwards the latched copy does, so later input changes are ignored.
    logic              cur_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic [2:0]        cur_funct3;
    logic              cur_err;
    logic [3:0]        be;
    logic [31:0]       wdata_lane, rdata_ext;
    logic [ADDR_W-3:0] idx;

    assign cur_we     = (state == IDLE) ? req_we     : lat.we;
    assign cur_addr   = (state == IDLE) ? req_addr   : lat.addr;
    assign cur_wdata  = (state == IDLE) ? req_wdata  : lat.wdata;
    assign cur_funct3 = (state == IDLE) ? req_funct3 : lat.funct3;
    assign idx        = cur_addr[ADDR_W-1:2];

    dmem_lane_align u_align (
        .we         (cur_we),
        .funct3     (cur_funct3),
        .addr_lo    (cur_addr[1:0]),
        .wdata      (cur_wdata),
        .rword      (mem[idx]),
        .err        (cur_err),
        .be         (be),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext)
    );

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        busy      = 1'b1;
        accept    = 1'b0;
        commit    = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    accept = 1'b1;
                    if (cur_err) begin
                        state_nx = RESP;
                    end else if (WAIT_CYC == 0) begin
                        state_nx = RESP;
                        commit   = 1'b1;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nx = RESP;
                    commit   = ~lat.err;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign rsp_valid = (state == RESP);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lat       <= '0;
            cnt       <= 4'd0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                lat <= '{we: req_we, addr: req_addr, wdata: req_wdata,
                         funct3: req_funct3, err: cur_err};
                cnt <= CNT_INIT;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end

            if (accept && cur_err) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end else if (commit) begin
                rsp_rdata <= cur_we ? '0 : rdata_ext;
                rsp_err   <= 1'b0;
            end
        end
    end

    // NOTE: the array has no reset; a store colliding with reset is dropped by gating the enable instead.
    always_ff @(posedge clk) begin
        if (commit && cur_we && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdata_lane[8*i +: 8];
            end
        end
    end

endmodule
